fpu_operand_unpack: RTL and testbench
=====================================

Name: fpu_operand_unpack

Overview:
- Pipelined front-end stage of the FPU arithmetic path. Sits directly upstream of the compare, add and mul sub-modules.
- Accepts two packed IEEE-754 single-precision operands with a valid/ready handshake.
- Registers the unpacked fields: sign, biased exponent, significand with hidden bit, and per-operand class flags (NaN/zero/inf/subnormal, signaling).
- Includes a 2-entry skid buffer, so back-pressure never creates a combinational ready path.

Parameters:
- TAG_W, 8, width of opaque sideband tag carried alongside operands (e.g. comp_func, rd index).
- EXP_W, 8, exponent field width (single precision, fixed).
- MAN_W, 23, stored mantissa width (single precision, fixed).

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous kill of all held entries.
- in_valid_i  in  1  operand pair valid.
- in_ready_o  out  1  stage can accept.
- op_a_i  in  32  packed operand A.
- op_b_i  in  32  packed operand B.
- tag_i  in  TAG_W  sideband.
- out_valid_o  out  1  unpacked pair valid.
- out_ready_i  in  1  consumer accepts.
- sign_a_o, sign_b_o  out  1  sign bits.
- exp_a_o, exp_b_o  out  EXP_W  raw biased exponent.
- sig_a_o, sig_b_o  out  MAN_W+1  {hidden, mantissa}.
- is_nan_a_o, is_nan_b_o  out  1  NaN (quiet or signaling).
- is_zero_a_o, is_zero_b_o  out  1  ±0.
- is_inf_a_o, is_inf_b_o  out  1  ±inf.
- is_sub_a_o, is_sub_b_o  out  1  subnormal.
- is_signaling_o  out  1  either operand is sNaN.
- tag_o  out  TAG_W  sideband.

Behaviour:
- Classification, per operand, combinational before the register:
  - hidden bit = (exp != 0).
  - zero = exp==0 & man==0.
  - sub = exp==0 & man!=0.
  - inf = exp==all-ones & man==0.
  - nan = exp==all-ones & man!=0.
  - sNaN = nan & man[MAN_W-1]==0.
  - Exponent passed raw; subnormals are not normalised.
- Storage: main register (M) drives the outputs; skid register (S) holds one extra entry. out_valid_o = M.valid. in_ready_o = !S.valid, a registered term only.
- Accept: in_valid_i & in_ready_o. Deliver: out_valid_o & out_ready_i.
- Per-cycle rules:
  - Accept into M when M is empty, or when M is delivering and S is empty.
  - Accept into S when M is held (valid & !out_ready_i) and S is empty.
  - On deliver with S valid: S moves to M, S is cleared, and in_ready_o rises next cycle.
  - Simultaneous deliver and accept with S empty: the new entry replaces M; no bubble.
- Latency: 1 cycle from accept to out_valid_o when unstalled. Throughput 1 per cycle.
- Ordering: strict FIFO. The entry in S is never delivered before the one in M.
- Outputs are stable while out_valid_o & !out_ready_i.
- flush_i: clears M.valid and S.valid next edge and has priority over a same-cycle accept; in_ready_o = 1 the following cycle. Data registers are not cleared.
- Reset (reset_i low, asynchronous): all valids 0, every data/flag output 0, in_ready_o 1. Reset mid-transfer drops held entries without delivery.
- Data registers load only on accept or skid move, to avoid extra toggling.

Optional Feature:
- FPU_FCLASS_EN defined: adds output fclass_a_o[9:0], registered and held with M. It is the RISC-V FCLASS.S one-hot mask for operand A:
  - bit0 -inf, 1 -normal, 2 -subnormal, 3 -0, 4 +0, 5 +subnormal, 6 +normal, 7 +inf, 8 sNaN, 9 qNaN.
  - The mask is stored in S as well.
- Undefined: the port and its storage are absent.

Decomposition:
- Shared package fpu_pkg:
  - EXP_W, MAN_W, EXP_BIAS=127, EXP_MAX=8'hFF.
  - Canonical qNaN 32'h7FC00000.
  - FCLASS bit index constants.
  - typedef fp_unpacked_t {sign, exp, sig, nan, zero, inf, sub, snan}.
- Sub-module fpu_classify: combinational, one operand to fp_unpacked_t, instantiated twice.

Test Plan:
- A=32'h3F800000, B=32'hBF800000, out_ready_i=1 → next cycle: sign_a=0, exp_a=8'h7F, sig_a=24'h800000; sign_b=1; all class flags 0; latency exactly 1.
- A=32'h7F800001 (sNaN), B=32'h7FC00000 (qNaN) → is_nan_a/b=1, is_signaling_o=1. B alone as qNaN → is_signaling_o=0.
- A=32'h00000001, B=32'h80000000 → is_sub_a=1, sig_a=24'h000001, exp_a=0; is_zero_b=1, sign_b=1.
- Back-to-back accepts of tags 1,2,3 with out_ready_i low for 3 cycles → in_ready_o drops after 2 accepts. Tag 3 is held off. Outputs stable at tag 1. After release, deliveries are 1,2,3 in order with no loss.
- Both entries full, then flush_i for 1 cycle with in_valid_i high → out_valid_o=0, the flush-cycle input is dropped, and in_ready_o=1 the next cycle.
- Assert reset_i low asynchronously mid-stall → out_valid_o=0 and outputs 0 immediately, without waiting for a clock edge. With FPU_FCLASS_EN, A=32'hFF800000 → fclass_a_o=10'h001.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared single-precision FPU definitions: field widths, special encodings,
// FCLASS bit positions and the unpacked-operand record.
package fpu_pkg;

  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int EXP_BIAS = 127;

  localparam logic [EXP_W-1:0] EXP_MAX    = 8'hFF;
  localparam logic [31:0]      CANON_QNAN = 32'h7FC00000;

  localparam int FCLASS_NEG_INF  = 0;
  localparam int FCLASS_NEG_NORM = 1;
  localparam int FCLASS_NEG_SUB  = 2;
  localparam int FCLASS_NEG_ZERO = 3;
  localparam int FCLASS_POS_ZERO = 4;
  localparam int FCLASS_POS_SUB  = 5;
  localparam int FCLASS_POS_NORM = 6;
  localparam int FCLASS_POS_INF  = 7;
  localparam int FCLASS_SNAN     = 8;
  localparam int FCLASS_QNAN     = 9;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   sig;
    logic             nan;
    logic             zero;
    logic             inf;
    logic             sub;
    logic             snan;
  } fp_unpacked_t;

  // One-hot RISC-V FCLASS.S mask derived from the already-computed class flags.
  function automatic logic [9:0] fclass_mask(input fp_unpacked_t u);
    logic [9:0] m;
    m = '0;
    if (u.nan)       m[u.snan ? FCLASS_SNAN : FCLASS_QNAN] = 1'b1;
    else if (u.inf)  m[u.sign ? FCLASS_NEG_INF : FCLASS_POS_INF] = 1'b1;
    else if (u.zero) m[u.sign ? FCLASS_NEG_ZERO : FCLASS_POS_ZERO] = 1'b1;
    else if (u.sub)  m[u.sign ? FCLASS_NEG_SUB : FCLASS_POS_SUB] = 1'b1;
    else             m[u.sign ? FCLASS_NEG_NORM : FCLASS_POS_NORM] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/fpu_classify.sv
// Combinational split of one packed single-precision operand into fields
// and class flags; subnormals are left un-normalised.
module fpu_classify
  import fpu_pkg::*;
(
  input  logic [31:0]  op,
  output fp_unpacked_t res
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  logic             exp_zero;
  logic             exp_ones;
  logic             man_zero;

  always_comb begin
    exp_f    = op[MAN_W +: EXP_W];
    man_f    = op[MAN_W-1:0];
    exp_zero = (exp_f == '0);
    exp_ones = (exp_f == EXP_MAX);
    man_zero = (man_f == '0);

    res      = '0;
    res.sign = op[31];
    res.exp  = exp_f;
    res.sig  = {!exp_zero, man_f};
    res.zero = exp_zero & man_zero;
    res.sub  = exp_zero & !man_zero;
    res.inf  = exp_ones & man_zero;
    res.nan  = exp_ones & !man_zero;
    res.snan = exp_ones & !man_zero & !man_f[MAN_W-1];
  end

endmodule

// File: rtl/fpu_operand_unpack.sv
// Registered operand-unpack stage with a 2-entry skid buffer (main + skid).
// Optional FCLASS.S mask for operand A is enabled by defining FPU_FCLASS_EN.
module fpu_operand_unpack #(
  parameter int TAG_W = 8,
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      op_a_i,
  input  logic [31:0]      op_b_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             sign_a_o,
  output logic             sign_b_o,
  output logic [EXP_W-1:0] exp_a_o,
  output logic [EXP_W-1:0] exp_b_o,
  output logic [MAN_W:0]   sig_a_o,
  output logic [MAN_W:0]   sig_b_o,
  output logic             is_nan_a_o,
  output logic             is_nan_b_o,
  output logic             is_zero_a_o,
  output logic             is_zero_b_o,
  output logic             is_inf_a_o,
  output logic             is_inf_b_o,
  output logic             is_sub_a_o,
  output logic             is_sub_b_o,
  output logic             is_signaling_o,
  output logic [TAG_W-1:0] tag_o
`ifdef FPU_FCLASS_EN
  ,
  output logic [9:0]       fclass_a_o
`endif
);

  import fpu_pkg::*;

  typedef struct packed {
    fp_unpacked_t     a;
    fp_unpacked_t     b;
    logic [TAG_W-1:0] tag;
`ifdef FPU_FCLASS_EN
    logic [9:0]       fclass;
`endif
  } entry_t;

  fp_unpacked_t cls_a;
  fp_unpacked_t cls_b;
  entry_t       in_entry;
  entry_t       m_q;
  entry_t       s_q;
  logic         m_valid_q;
  logic         s_valid_q;
  logic         accept;
  logic         deliver;

  fpu_classify u_cls_a (.op(op_a_i), .res(cls_a));
  fpu_classify u_cls_b (.op(op_b_i), .res(cls_b));

  always_comb begin
    in_entry     = '0;
    in_entry.a   = cls_a;
    in_entry.b   = cls_b;
    in_entry.tag = tag_i;
`ifdef FPU_FCLASS_EN
    in_entry.fclass = fclass_mask(cls_a);
`endif
  end

  // Ready depends only on the skid flop, so no combinational path from out_ready_i.
  assign in_ready_o  = !s_valid_q;
  assign accept      = in_valid_i & !s_valid_q;
  assign deliver     = m_valid_q & out_ready_i;
  assign out_valid_o = m_valid_q;

  // M refills from S first (FIFO order), else from the input; S only catches
  // an accept while M is stalled. Data flops load only when an entry moves in.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_q       <= '0;
      s_q       <= '0;
    end else if (flush_i) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
    end else if (!m_valid_q || deliver) begin
      if (s_valid_q) begin
        m_q       <= s_q;
        m_valid_q <= 1'b1;
        s_valid_q <= 1'b0;
      end else if (accept) begin
        m_q       <= in_entry;
        m_valid_q <= 1'b1;
      end else begin
        m_valid_q <= 1'b0;
      end
    end else if (accept) begin
      s_q       <= in_entry;
      s_valid_q <= 1'b1;
    end
  end

  assign sign_a_o       = m_q.a.sign;
  assign sign_b_o       = m_q.b.sign;
  assign exp_a_o        = m_q.a.exp;
  assign exp_b_o        = m_q.b.exp;
  assign sig_a_o        = m_q.a.sig;
  assign sig_b_o        = m_q.b.sig;
  assign is_nan_a_o     = m_q.a.nan;
  assign is_nan_b_o     = m_q.b.nan;
  assign is_zero_a_o    = m_q.a.zero;
  assign is_zero_b_o    = m_q.b.zero;
  assign is_inf_a_o     = m_q.a.inf;
  assign is_inf_b_o     = m_q.b.inf;
  assign is_sub_a_o     = m_q.a.sub;
  assign is_sub_b_o     = m_q.b.sub;
  assign is_signaling_o = m_q.a.snan | m_q.b.snan;
  assign tag_o          = m_q.tag;
`ifdef FPU_FCLASS_EN
  assign fclass_a_o     = m_q.fclass;
`endif

endmodule

// File: tb/tb_fpu_operand_unpack.sv
// Directed, table-driven bench for fpu_operand_unpack plus hand-written
// back-pressure, flush and asynchronous-reset sequences.
module tb_fpu_operand_unpack;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] op_a_i = '0;
  logic [31:0] op_b_i = '0;
  logic [7:0]  tag_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic        sign_a_o, sign_b_o;
  logic [7:0]  exp_a_o, exp_b_o;
  logic [23:0] sig_a_o, sig_b_o;
  logic        is_nan_a_o, is_nan_b_o, is_zero_a_o, is_zero_b_o;
  logic        is_inf_a_o, is_inf_b_o, is_sub_a_o, is_sub_b_o;
  logic        is_signaling_o;
  logic [7:0]  tag_o;
`ifdef FPU_FCLASS_EN
  logic [9:0]  fclass_a_o;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  fpu_operand_unpack #(.TAG_W(8), .EXP_W(8), .MAN_W(23)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .tag_i(tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .sign_a_o(sign_a_o), .sign_b_o(sign_b_o),
    .exp_a_o(exp_a_o), .exp_b_o(exp_b_o),
    .sig_a_o(sig_a_o), .sig_b_o(sig_b_o),
    .is_nan_a_o(is_nan_a_o), .is_nan_b_o(is_nan_b_o),
    .is_zero_a_o(is_zero_a_o), .is_zero_b_o(is_zero_b_o),
    .is_inf_a_o(is_inf_a_o), .is_inf_b_o(is_inf_b_o),
    .is_sub_a_o(is_sub_a_o), .is_sub_b_o(is_sub_b_o),
    .is_signaling_o(is_signaling_o), .tag_o(tag_o)
`ifdef FPU_FCLASS_EN
    , .fclass_a_o(fclass_a_o)
`endif
  );

  // Field flags are packed {nan, zero, inf, sub}.
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  tag;
    logic        sa;
    logic [7:0]  ea;
    logic [23:0] ga;
    logic [3:0]  fa;
    logic        sb;
    logic [7:0]  eb;
    logic [23:0] gb;
    logic [3:0]  fb;
    logic        snan;
    logic [9:0]  fcl;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [82:0] observed();
    return {sign_a_o, exp_a_o, sig_a_o,
            {is_nan_a_o, is_zero_a_o, is_inf_a_o, is_sub_a_o},
            sign_b_o, exp_b_o, sig_b_o,
            {is_nan_b_o, is_zero_b_o, is_inf_b_o, is_sub_b_o},
            is_signaling_o, tag_o};
  endfunction

  function automatic logic [82:0] expected(input vec_t v);
    return {v.sa, v.ea, v.ga, v.fa, v.sb, v.eb, v.gb, v.fb, v.snan, v.tag};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a,
                               input logic [31:0] b, input logic [7:0] t);
    in_valid_i = v;
    op_a_i     = a;
    op_b_i     = b;
    tag_i      = t;
  endtask

  task automatic cycle();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    vecs[0] = '{32'h3F800000, 32'hBF800000, 8'h11, 1'b0, 8'h7F, 24'h800000, 4'b0000,
                1'b1, 8'h7F, 24'h800000, 4'b0000, 1'b0, 10'h040};
    vecs[1] = '{32'h7F800001, 32'h7FC00000, 8'h12, 1'b0, 8'hFF, 24'h800001, 4'b1000,
                1'b0, 8'hFF, 24'hC00000, 4'b1000, 1'b1, 10'h100};
    vecs[2] = '{32'h3F800000, 32'h7FC00000, 8'h13, 1'b0, 8'h7F, 24'h800000, 4'b0000,
                1'b0, 8'hFF, 24'hC00000, 4'b1000, 1'b0, 10'h040};
    vecs[3] = '{32'h00000001, 32'h80000000, 8'h14, 1'b0, 8'h00, 24'h000001, 4'b0001,
                1'b1, 8'h00, 24'h000000, 4'b0100, 1'b0, 10'h020};
    vecs[4] = '{32'h7F800000, 32'hFF800000, 8'h15, 1'b0, 8'hFF, 24'h800000, 4'b0010,
                1'b1, 8'hFF, 24'h800000, 4'b0010, 1'b0, 10'h080};
    vecs[5] = '{32'h7FBFFFFF, 32'h00800000, 8'h16, 1'b0, 8'hFF, 24'hBFFFFF, 4'b1000,
                1'b0, 8'h01, 24'h800000, 4'b0000, 1'b1, 10'h100};
    vecs[6] = '{32'h807FFFFF, 32'h7F7FFFFF, 8'h17, 1'b1, 8'h00, 24'h7FFFFF, 4'b0001,
                1'b0, 8'hFE, 24'hFFFFFF, 4'b0000, 1'b0, 10'h004};

    repeat (2) @(negedge clk_i);
    checkOutput("reset_out_valid", 128'(out_valid_o), 128'(1'b0));
    checkOutput("reset_in_ready", 128'(in_ready_o), 128'(1'b1));
    checkOutput("reset_fields", 128'(observed()), 128'(0));
    reset_i = 1'b1;
    @(negedge clk_i);

    // Table vectors: one accept, then an idle cycle to see the entry leave.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, vecs[i].a, vecs[i].b, vecs[i].tag);
      checkOutput($sformatf("v%0d_pre_valid", i), 128'(out_valid_o), 128'(1'b0));
      cycle();
      applyStimulus(1'b0, 32'h0, 32'h0, 8'h0);
      checkOutput($sformatf("v%0d_latency_valid", i), 128'(out_valid_o), 128'(1'b1));
      checkOutput($sformatf("v%0d_fields", i), 128'(observed()), 128'(expected(vecs[i])));
`ifdef FPU_FCLASS_EN
      checkOutput($sformatf("v%0d_fclass", i), 128'(fclass_a_o), 128'(vecs[i].fcl));
`endif
      cycle();
      checkOutput($sformatf("v%0d_drained", i), 128'(out_valid_o), 128'(1'b0));
    end

    // Back-pressure: tags 1,2 fill M and S, tag 3 is held off.
    out_ready_i = 1'b0;
    applyStimulus(1'b1, 32'h3F800000, 32'h40000000, 8'd1);
    cycle();
    applyStimulus(1'b1, 32'h3F800000, 32'h40000000, 8'd2);
    checkOutput("bp_ready_after_1", 128'(in_ready_o), 128'(1'b1));
    cycle();
    applyStimulus(1'b1, 32'h3F800000, 32'h40000000, 8'd3);
    checkOutput("bp_ready_after_2", 128'(in_ready_o), 128'(1'b0));
    checkOutput("bp_tag_hold1", 128'(tag_o), 128'(8'd1));
    cycle();
    checkOutput("bp_ready_still_low", 128'(in_ready_o), 128'(1'b0));
    checkOutput("bp_tag_hold2", 128'(tag_o), 128'(8'd1));
    checkOutput("bp_valid_held", 128'(out_valid_o), 128'(1'b1));
    out_ready_i = 1'b1;
    cycle();
    checkOutput("bp_deliver2_tag", 128'(tag_o), 128'(8'd2));
    checkOutput("bp_ready_rises", 128'(in_ready_o), 128'(1'b1));
    cycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 8'h0);
    checkOutput("bp_deliver3_tag", 128'(tag_o), 128'(8'd3));
    checkOutput("bp_deliver3_valid", 128'(out_valid_o), 128'(1'b1));
    cycle();
    checkOutput("bp_empty", 128'(out_valid_o), 128'(1'b0));

    // Flush with both entries full and a same-cycle input.
    out_ready_i = 1'b0;
    applyStimulus(1'b1, 32'h3F800000, 32'h3F800000, 8'd4);
    cycle();
    applyStimulus(1'b1, 32'h3F800000, 32'h3F800000, 8'd5);
    cycle();
    checkOutput("fl_full", 128'(in_ready_o), 128'(1'b0));
    applyStimulus(1'b1, 32'h3F800000, 32'h3F800000, 8'd6);
    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 8'h0);
    checkOutput("fl_valid", 128'(out_valid_o), 128'(1'b0));
    checkOutput("fl_ready", 128'(in_ready_o), 128'(1'b1));
    out_ready_i = 1'b1;
    cycle();
    checkOutput("fl_input_dropped", 128'(out_valid_o), 128'(1'b0));

    // Asynchronous reset while stalled, between clock edges.
    out_ready_i = 1'b0;
    applyStimulus(1'b1, 32'hFF800000, 32'hBF800000, 8'd7);
    cycle();
    applyStimulus(1'b1, 32'h3F800000, 32'h3F800000, 8'd8);
`ifdef FPU_FCLASS_EN
    checkOutput("fclass_neg_inf", 128'(fclass_a_o), 128'(10'h001));
`endif
    checkOutput("rst_pre_tag", 128'(tag_o), 128'(8'd7));
    cycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 8'h0);
    #2 reset_i = 1'b0;
    #1;
    checkOutput("rst_async_valid", 128'(out_valid_o), 128'(1'b0));
    checkOutput("rst_async_ready", 128'(in_ready_o), 128'(1'b1));
    checkOutput("rst_async_fields", 128'(observed()), 128'(0));
`ifdef FPU_FCLASS_EN
    checkOutput("rst_async_fclass", 128'(fclass_a_o), 128'(0));
`endif
    @(negedge clk_i);
    reset_i = 1'b1;
    out_ready_i = 1'b1;
    cycle();
    checkOutput("rst_dropped", 128'(out_valid_o), 128'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
